// File: rtl/bin2bcd_8_pkg.sv
// bin2bcd_8_pkg: shared widths, FSM state and digit type for the binary-to-BCD converter
package bin2bcd_8_pkg;
   localparam int BIN_W = 8;
   localparam int BCD_DIGITS = 3;
   localparam int ITER = 8;
   localparam int WORK_W = BIN_W + 4 * BCD_DIGITS;
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   typedef logic [3:0] bcd_t;
endpackage

// File: rtl/bin2bcd_8_bcd_add3.sv
// bin2bcd_8_bcd_add3: double-dabble nibble corrector, adds 3 to any digit of 5 or more
module bin2bcd_8_bcd_add3
   import bin2bcd_8_pkg::*;
(
   input  bcd_t d_in,
   output bcd_t d_out
);
   assign d_out = (d_in >= 4'd5) ? d_in + 4'd3 : d_in;
endmodule

// File: rtl/bin2bcd_8.sv
// bin2bcd_8: iterative 8-bit binary to 3-digit BCD converter with valid/ready handshakes
module bin2bcd_8
   import bin2bcd_8_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] bin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] centaines,
   output logic [3:0] dizaines,
   output logic [3:0] unites
);
   state_t state_q, state_d;
   logic [WORK_W-1:0] work_q, work_d, adj, sh;
   logic [3:0] cnt_q, cnt_d;
   logic [4*BCD_DIGITS-1:0] dig_q, dig_d;
   logic accept, conv, last;
   genvar i;
   for (i = 0; i < BCD_DIGITS; i++) begin : g_add3
      bin2bcd_8_bcd_add3 u_add3 (
         .d_in  (work_q[BIN_W+4*i +: 4]),
         .d_out (adj[BIN_W+4*i +: 4])
      );
   end
   assign adj[BIN_W-1:0] = work_q[BIN_W-1:0];
   assign sh = adj << 1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      accept = (state_q == IDLE) && in_valid;
      conv = (state_q == CONV);
      last = conv && (cnt_q == 4'(ITER - 1));
      state_d = accept ? CONV :
                last ? DONE :
                (state_q == DONE && out_ready) ? IDLE : state_q;
   end
   always_comb begin
      work_d = accept ? {{(4*BCD_DIGITS){1'b0}}, bin} : conv ? sh : work_q;
      cnt_d = accept ? 4'd0 : conv ? cnt_q + 4'd1 : cnt_q;
      dig_d = last ? sh[WORK_W-1:BIN_W] : dig_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         work_q <= '0;
         cnt_q <= '0;
         dig_q <= '0;
      end else begin
         work_q <= work_d;
         cnt_q <= cnt_d;
         dig_q <= dig_d;
      end
   always_comb begin
      in_ready = (state_q == IDLE);
      out_valid = (state_q == DONE);
      centaines = dig_q[11:8];
      dizaines = dig_q[7:4];
      unites = dig_q[3:0];
   end
endmodule

// File: tb/tb_bin2bcd_8.sv
// tb_bin2bcd_8: randomized and directed checks of bin2bcd_8 against a decimal-arithmetic model
module tb_bin2bcd_8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [7:0] bin = 8'd0;
   logic in_ready, out_valid;
   logic [3:0] centaines, dizaines, unites;
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic m_idle, m_ov;
   int m_cnt, m_val, m_c, m_d, m_u;

   always #5 clk = ~clk;

   bin2bcd_8 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .centaines (centaines),
      .dizaines  (dizaines),
      .unites    (unites)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: accept when idle, result 8 edges later as plain decimal division, hold until taken
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_idle <= 1'b1;
         m_ov <= 1'b0;
         m_cnt <= 0;
         m_val <= 0;
         m_c <= 0;
         m_d <= 0;
         m_u <= 0;
      end else if (m_idle) begin
         if (in_valid) begin
            m_idle <= 1'b0;
            m_val <= int'(bin);
            m_cnt <= 8;
         end
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_ov <= 1'b1;
            m_c <= m_val / 100;
            m_d <= (m_val / 10) % 10;
            m_u <= m_val % 10;
         end
      end else if (out_ready) begin
         m_ov <= 1'b0;
         m_idle <= 1'b1;
      end

   always @(negedge clk)
      if (rst_n) begin
         chk("in_ready", in_ready, m_idle);
         chk("out_valid", out_valid, m_ov);
         chk("centaines", centaines, m_c);
         chk("dizaines", dizaines, m_d);
         chk("unites", unites, m_u);
      end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] v);
      int n = 0;
      while (!in_ready && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 30) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      bin = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      bin = 8'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic chk_dig(input string name, input int c, input int d, input int u);
      chk({name, "_c"}, centaines, c);
      chk({name, "_d"}, dizaines, d);
      chk({name, "_u"}, unites, u);
   endtask

   int bv[6] = '{0, 9, 10, 99, 100, 255};
   int bc[6] = '{0, 0, 0, 0, 1, 2};
   int bd[6] = '{0, 0, 1, 9, 0, 5};
   int bu[6] = '{0, 9, 0, 9, 0, 5};

   initial begin
      int lat, prev, rises;
      logic last_ov;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk_dig("rst", 0, 0, 0);
      rst_n = 1'b1;
      for (int v = 0; v < 256; v++) begin
         send(v[7:0]);
         wait_valid(lat);
         chk("latency", lat, 8);
         chk("sum", centaines * 100 + dizaines * 10 + unites, v);
         handoff();
      end
      for (int k = 0; k < 6; k++) begin
         send(bv[k][7:0]);
         wait_valid(lat);
         chk_dig("edge", bc[k], bd[k], bu[k]);
         chk("model_edge_c", m_c, bc[k]);
         chk("model_edge_d", m_d, bd[k]);
         chk("model_edge_u", m_u, bu[k]);
         handoff();
      end
      send(8'd200);
      wait_valid(lat);
      chk("bp_latency", lat, 8);
      repeat (20) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         bin = 8'd17;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk_dig("bp", 2, 0, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_in_ready", in_ready, 1);
      chk("release_out_valid", out_valid, 0);
      send(8'd17);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("hold_out_valid", out_valid, 0);
      chk_dig("hold", 2, 0, 0);
      wait_valid(lat);
      chk("reuse_valid", out_valid, 1);
      chk_dig("reuse", 0, 1, 7);
      handoff();
      send(8'd255);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk_dig("arst", 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(8'd128);
      wait_valid(lat);
      chk("post_rst_latency", lat, 8);
      chk_dig("post_rst", 1, 2, 8);
      handoff();
      out_ready = 1'b1;
      in_valid = 1'b1;
      prev = -1;
      rises = 0;
      last_ov = 1'b0;
      for (int k = 0; k < 100; k++) begin
         bin = 8'($urandom);
         @(posedge clk); #1;
         if (out_valid && !last_ov) begin
            if (prev >= 0) chk("b2b_period_ge9", int'((cyc - prev) >= 9), 1);
            prev = cyc;
            rises++;
         end
         last_ov = out_valid;
      end
      chk("b2b_results", int'(rises >= 8), 1);
      in_valid = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      for (int k = 0; k < 400; k++) begin
         in_valid = 1'($urandom);
         out_ready = ($urandom_range(0, 3) == 0);
         bin = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
